// File: rtl/pcc_mode_scheduler.sv
// Tick prescaler, one-entry command buffer and mode sequencer driving every PCC replica (SENSOR_WAKE_EN adds sensor wake).
// Tick updates appear the cycle after pcc_en; cmd_ready is low while a command waits for its tick.
module pcc_mode_scheduler #(
    parameter int unsigned TICK_DIV      = 1000,
    parameter int unsigned LINK_TIMEOUT  = 64,
    parameter int unsigned SLEEP_TIMEOUT = 256,
    parameter logic [3:0]  DEF_SPEED     = 4'd5,
    parameter logic [3:0]  DEF_DIR       = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_speed,
    input  logic [3:0] cmd_dir,
    input  logic [1:0] cmd_mode,
    input  logic       f1,
    input  logic       f2,
    input  logic       b1,
    input  logic       b2,
    output logic       pcc_en,
    output logic [1:0] mode_o,
    output logic [3:0] speed_o,
    output logic [3:0] dir_o,
    output logic       link_lost
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int LW = $clog2(LINK_TIMEOUT + 1);
    localparam int IW = $clog2(SLEEP_TIMEOUT + 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LINK_MAX  = LW'(LINK_TIMEOUT);
    localparam logic [LW-1:0] LINK_LAST = LW'(LINK_TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(SLEEP_TIMEOUT);

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_HYBRID = 2'd1,
        MODE_MANUAL = 2'd2,
        MODE_SLEEP  = 2'd3
    } mode_t;

    mode_t          mode_q;
    mode_t          mode_d;
    logic [3:0]     speed_d;
    logic [3:0]     dir_d;
    logic           lost_d;

    logic           run;
    logic [PW-1:0]  pre_cnt;
    logic           tick;

    logic           pend_full;
    logic [3:0]     pend_speed;
    logic [3:0]     pend_dir;
    logic [1:0]     pend_mode;

    logic [LW-1:0]  link_cnt;
    logic [LW-1:0]  link_inc;
    logic [LW-1:0]  link_next;
    logic [IW-1:0]  idle_cnt;
    logic [IW-1:0]  idle_inc;
    logic [IW-1:0]  idle_next;

    logic           accept;
    logic           apply;
    logic [3:0]     app_speed;
    logic [3:0]     app_dir;
    logic [1:0]     app_mode;
    logic           sensor_act;
    logic           wd_fire;
    logic           sleep_go;
    logic           wake_go;

`ifdef SENSOR_WAKE_EN
    assign sensor_act = f1 | f2 | b1 | b2;
`else
    logic sensor_unused;
    assign sensor_unused = f1 ^ f2 ^ b1 ^ b2;
    assign sensor_act    = 1'b0;
`endif

    // run holds the prescaler for one cycle after reset so the first tick lands TICK_DIV cycles after release
    assign tick      = run && (pre_cnt == TICK_LAST);
    assign pcc_en    = tick;
    assign cmd_ready = run && !pend_full;
    assign accept    = cmd_valid && cmd_ready;
    assign apply     = tick && (pend_full || accept);

    assign app_speed = pend_full ? pend_speed : cmd_speed;
    assign app_dir   = pend_full ? pend_dir   : cmd_dir;
    assign app_mode  = pend_full ? pend_mode  : cmd_mode;

    assign link_inc  = (link_cnt == LINK_MAX) ? link_cnt : link_cnt + 1'b1;
    assign link_next = apply ? '0 : link_inc;
    assign idle_inc  = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;
    assign idle_next = (apply || sensor_act) ? '0 : idle_inc;

    // Watchdog fires only on the tick that reaches the limit so a later sleep entry is not starved
    assign wd_fire   = tick && !apply && (link_cnt == LINK_LAST);
    assign sleep_go  = tick && (mode_q == MODE_AUTO) && (idle_next == IDLE_MAX);
    assign wake_go   = tick && (mode_q == MODE_SLEEP) && sensor_act;

    always_comb begin
        mode_d  = mode_q;
        speed_d = speed_o;
        dir_d   = dir_o;
        lost_d  = link_lost;
        if (apply) begin
            mode_d  = mode_t'(app_mode);
            speed_d = app_speed;
            dir_d   = app_dir;
            lost_d  = 1'b0;
        end else if (wd_fire) begin
            lost_d  = 1'b1;
            speed_d = DEF_SPEED;
            dir_d   = DEF_DIR;
            if (mode_q == MODE_HYBRID || mode_q == MODE_MANUAL) begin
                mode_d = MODE_AUTO;
            end
        end else if (sleep_go) begin
            mode_d = MODE_SLEEP;
        end else if (wake_go) begin
            mode_d = MODE_AUTO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_SLEEP;
            speed_o   <= 4'd0;
            dir_o     <= DEF_DIR;
            link_lost <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            speed_o   <= speed_d;
            dir_o     <= dir_d;
            link_lost <= lost_d;
        end
    end

    assign mode_o = mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run        <= 1'b0;
            pre_cnt    <= '0;
            pend_full  <= 1'b0;
            pend_speed <= 4'd0;
            pend_dir   <= 4'd0;
            pend_mode  <= 2'd0;
            link_cnt   <= '0;
            idle_cnt   <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            end
            if (tick) begin
                pend_full <= 1'b0;
                link_cnt  <= link_next;
                idle_cnt  <= idle_next;
            end else if (accept) begin
                pend_full  <= 1'b1;
                pend_speed <= cmd_speed;
                pend_dir   <= cmd_dir;
                pend_mode  <= cmd_mode;
            end
        end
    end
endmodule

// File: tb/tb_pcc_mode_scheduler.sv
// Directed plus randomized stimulus for pcc_mode_scheduler, checked every cycle against a tick-level reference model.
module tb_pcc_mode_scheduler;
    localparam int TD = 4;
    localparam int LT = 3;
    localparam int ST = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_speed;
    logic [3:0] cmd_dir;
    logic [1:0] cmd_mode;
    logic       f1, f2, b1, b2;
    logic       pcc_en;
    logic [1:0] mode_o;
    logic [3:0] speed_o;
    logic [3:0] dir_o;
    logic       link_lost;

    always #5 clk = ~clk;

    pcc_mode_scheduler #(
        .TICK_DIV     (TD),
        .LINK_TIMEOUT (LT),
        .SLEEP_TIMEOUT(ST),
        .DEF_SPEED    (4'd5),
        .DEF_DIR      (4'd8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_speed(cmd_speed),
        .cmd_dir  (cmd_dir),
        .cmd_mode (cmd_mode),
        .f1       (f1),
        .f2       (f2),
        .b1       (b1),
        .b2       (b2),
        .pcc_en   (pcc_en),
        .mode_o   (mode_o),
        .speed_o  (speed_o),
        .dir_o    (dir_o),
        .link_lost(link_lost)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: cycles since release, pending command, and tick counts since last command / activity
    int         m_cyc;
    bit         m_pend;
    logic [3:0] p_speed, p_dir;
    logic [1:0] p_mode;
    logic [1:0] m_mode;
    logic [3:0] m_speed, m_dir;
    bit         m_lost;
    int         since_cmd, since_act;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, m_cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc     = 0;
        m_pend    = 0;
        p_speed   = 4'd0;
        p_dir     = 4'd0;
        p_mode    = 2'd0;
        m_mode    = 2'd3;
        m_speed   = 4'd0;
        m_dir     = 4'd8;
        m_lost    = 0;
        since_cmd = 0;
        since_act = 0;
    endtask

    function automatic bit model_tick();
        return (m_cyc > 0) && (m_cyc % TD == 0);
    endfunction

    task automatic check_outputs();
        chk("pcc_en",    {7'd0, pcc_en},    {7'd0, model_tick()});
        chk("cmd_ready", {7'd0, cmd_ready}, {7'd0, (m_cyc > 0) && !m_pend});
        chk("mode_o",    {6'd0, mode_o},    {6'd0, m_mode});
        chk("speed_o",   {4'd0, speed_o},   {4'd0, m_speed});
        chk("dir_o",     {4'd0, dir_o},     {4'd0, m_dir});
        chk("link_lost", {7'd0, link_lost}, {7'd0, m_lost});
    endtask

    task automatic model_advance(input bit v, input logic [3:0] s, input logic [3:0] d,
                                 input logic [1:0] m, input logic [3:0] sens);
        bit         acc;
        bit         act;
        bit         app;
        logic [3:0] a_s, a_d;
        logic [1:0] a_m;
        acc = v && (m_cyc > 0) && !m_pend;
`ifdef SENSOR_WAKE_EN
        act = (sens != 4'd0);
`else
        act = (sens == 4'hF) && 1'b0;
`endif
        if (model_tick()) begin
            app = m_pend || acc;
            a_s = m_pend ? p_speed : s;
            a_d = m_pend ? p_dir   : d;
            a_m = m_pend ? p_mode  : m;
            m_pend    = 0;
            since_cmd = app ? 0 : since_cmd + 1;
            since_act = (app || act) ? 0 : since_act + 1;
            if (app) begin
                m_mode  = a_m;
                m_speed = a_s;
                m_dir   = a_d;
                m_lost  = 0;
            end else if (since_cmd == LT) begin
                m_lost  = 1;
                m_speed = 4'd5;
                m_dir   = 4'd8;
                if (m_mode == 2'd1 || m_mode == 2'd2) m_mode = 2'd0;
            end else if (m_mode == 2'd0 && since_act >= ST) begin
                m_mode = 2'd3;
            end else if (m_mode == 2'd3 && act) begin
                m_mode = 2'd0;
            end
        end else if (acc) begin
            m_pend  = 1;
            p_speed = s;
            p_dir   = d;
            p_mode  = m;
        end
        m_cyc++;
    endtask

    // Called at a falling edge: check state, drive this cycle's inputs, advance the model over the next rising edge
    task automatic step(input bit v, input logic [3:0] s, input logic [3:0] d,
                        input logic [1:0] m, input logic [3:0] sens);
        check_outputs();
        cmd_valid = v;
        cmd_speed = s;
        cmd_dir   = d;
        cmd_mode  = m;
        {f1, f2, b1, b2} = sens;
        model_advance(v, s, d, m, sens);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
    endtask

    task automatic to_tick();
        for (int i = 0; i < TD && !model_tick(); i++) step(1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
    endtask

    task automatic do_reset(input int hold);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_pcc_en",    {7'd0, pcc_en},    8'd0);
        chk("rst_cmd_ready", {7'd0, cmd_ready}, 8'd0);
        chk("rst_mode_o",    {6'd0, mode_o},    8'd3);
        chk("rst_speed_o",   {4'd0, speed_o},   8'd0);
        chk("rst_dir_o",     {4'd0, dir_o},     8'd8);
        chk("rst_link_lost", {7'd0, link_lost}, 8'd0);
        model_reset();
        repeat (hold) @(negedge clk);
        cmd_valid = 1'b0;
        {f1, f2, b1, b2} = 4'd0;
        rst = 1'b0;
    endtask

    initial begin
        int rate;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_speed = 4'd0;
        cmd_dir   = 4'd0;
        cmd_mode  = 2'd0;
        {f1, f2, b1, b2} = 4'd0;
        model_reset();
        @(negedge clk);

        // Idle after reset: ticks at 4, 8, 12, mode 3 / speed 0 / dir 8
        do_reset(3);
        idle(14);

        // Command in cycle 1, applied at the first tick
        do_reset(2);
        idle(1);
        step(1'b1, 4'd9, 4'd2, 2'd2, 4'd0);
        idle(4);

        // Write-through in a tick cycle with pending empty
        to_tick();
        step(1'b1, 4'd7, 4'd3, 2'd1, 4'd0);

        // Silence: watchdog on the 3rd tick, then sleep after 5 idle ticks in auto
        idle(3 * TD + 1);
        idle(2 * TD + 2);

        // Sensor at a tick in sleep
        to_tick();
        step(1'b0, 4'd0, 4'd0, 2'd0, 4'b1000);
        idle(TD + 1);

        // New command clears link_lost
        step(1'b1, 4'd4, 4'd6, 2'd2, 4'd0);
        idle(TD + 1);

        // Mode 3 command enters sleep directly
        step(1'b1, 4'd1, 4'd1, 2'd3, 4'd0);
        idle(TD + 1);

        // Reset while a command is pending; it must never be applied
        to_tick();
        idle(1);
        step(1'b1, 4'd6, 4'd6, 2'd2, 4'd0);
        idle(1);
        do_reset(2);
        idle(3 * TD + 2);

        // Randomized traffic with varying command density
        for (int i = 0; i < 900; i++) begin
            if (i % 150 == 0) rate = (i / 150) % 3 == 0 ? 3 : ((i / 150) % 3 == 1 ? 20 : 70);
            if (i == 450) do_reset(1);
            step($urandom_range(0, rate) == 0, 4'($urandom), 4'($urandom), 2'($urandom),
                 ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
